layer_read_compositor: RTL and testbench

// Display-side reader for the three drawing-layer framebuffers. Each pixel it generates one

---
 rtl/layer_read_compositor_if.sv | 15 +
 rtl/layer_read_compositor.sv | 119 +++++++++++
 tb/tb_layer_read_compositor.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_read_compositor_if.sv
// Read port between the compositor and the three layer framebuffers.
interface layer_read_compositor_if #(
    parameter int ADDR_W = 19
) ();
    // Strobe-only port with no valid/ready pair: each clock with rd_en high is one read of rd_addr
    // that the memories always accept, and l1/l2/l3_data carry that address's words MEM_LAT clocks later.
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [12:0]       l1_data;
    logic [12:0]       l2_data;
    logic [12:0]       l3_data;

    modport master (output rd_en, rd_addr, input l1_data, l2_data, l3_data);
    modport slave  (input rd_en, rd_addr, output l1_data, l2_data, l3_data);
endinterface

// File: rtl/layer_read_compositor.sv
// Display-side layer reader: one framebuffer read per pixel, layer merge plus cursor outline,
// with the syncs and frame marker delayed to stay aligned with the returned pixel data.
module layer_read_compositor #(
    parameter int          H_RES     = 640,
    parameter int          V_RES     = 480,
    parameter int          ADDR_W    = 19,
    parameter int          MEM_LAT   = 1,
    parameter logic [11:0] BG_COLOR  = 12'h000,
    parameter logic [11:0] CUR_COLOR = 12'hFFF,
    parameter logic        SYNC_IDLE = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          video_on,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic [9:0]                    x,
    input  logic [9:0]                    y,
    input  logic [9:0]                    cursor_x,
    input  logic [9:0]                    cursor_y,
    input  logic [1:0]                    cursor_size,
    input  logic [2:0]                    show_layer,
    layer_read_compositor_if.master       mem,
    output logic [11:0]                   rgb_out,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic                          frame_start
);
    generate
        if (MEM_LAT < 1 || MEM_LAT > 3) begin : g_bad_mem_lat
            $error("layer_read_compositor: MEM_LAT must be in 1..3");
        end
    endgenerate

    localparam int                DL    = MEM_LAT + 1;
    localparam logic [10:0]       H_LIM = 11'(H_RES);
    localparam logic [10:0]       V_LIM = 11'(V_RES);
    localparam logic [ADDR_W-1:0] H_MUL = ADDR_W'(H_RES);

    logic        a_range, a_hit, a_origin, in_box, on_edge;
    logic [10:0] x11, y11, cx11, cy11, size_s, cx_end, cy_end;

    // Cursor bounds live in 11 bits so a box hanging off the right/bottom edge clips instead of wrapping.
    always_comb begin
        x11  = {1'b0, x};
        y11  = {1'b0, y};
        cx11 = {1'b0, cursor_x};
        cy11 = {1'b0, cursor_y};
        case (cursor_size)
            2'b00:   size_s = 11'd4;
            2'b01:   size_s = 11'd8;
            2'b10:   size_s = 11'd20;
            default: size_s = 11'd0;
        endcase
        cx_end   = cx11 + size_s;
        cy_end   = cy11 + size_s;
        in_box   = (cursor_size != 2'b11) && (x11 >= cx11) && (x11 < cx_end)
                   && (y11 >= cy11) && (y11 < cy_end);
        on_edge  = (x11 == cx11) || (x11 == cx_end - 11'd1)
                   || (y11 == cy11) || (y11 == cy_end - 11'd1);
        a_hit    = in_box && on_edge;
        a_range  = video_on && (x11 < H_LIM) && (y11 < V_LIM);
        a_origin = a_range && (x == 10'd0) && (y == 10'd0);
    end

    // Side information rides alongside the memory read; stage DL-1 lines up with the returned words.
    logic [DL-1:0] dl_range, dl_hit, dl_hs, dl_vs, dl_org;
    logic [2:0]    dl_show [DL];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem.rd_en   <= 1'b0;
            mem.rd_addr <= '0;
            dl_range    <= '0;
            dl_hit      <= '0;
            dl_hs       <= {DL{SYNC_IDLE}};
            dl_vs       <= {DL{SYNC_IDLE}};
            dl_org      <= '0;
            for (int i = 0; i < DL; i++) dl_show[i] <= '0;
        end else begin
            mem.rd_en   <= a_range;
            mem.rd_addr <= a_range ? (ADDR_W'(y) * H_MUL + ADDR_W'(x)) : '0;
            dl_range    <= {dl_range[DL-2:0], a_range};
            dl_hit      <= {dl_hit[DL-2:0], a_hit};
            dl_hs       <= {dl_hs[DL-2:0], hsync_in};
            dl_vs       <= {dl_vs[DL-2:0], vsync_in};
            dl_org      <= {dl_org[DL-2:0], a_origin};
            dl_show[0]  <= show_layer;
            for (int i = 1; i < DL; i++) dl_show[i] <= dl_show[i-1];
        end
    end

    logic [11:0] px;
    logic [2:0]  show_c;

    always_comb begin
        show_c = dl_show[DL-1];
        px     = BG_COLOR;
        if (!dl_range[DL-1])                    px = 12'h000;
        else if (dl_hit[DL-1])                  px = CUR_COLOR;
        else if (mem.l3_data[12] && show_c[2])  px = mem.l3_data[11:0];
        else if (mem.l2_data[12] && show_c[1])  px = mem.l2_data[11:0];
        else if (mem.l1_data[12] && show_c[0])  px = mem.l1_data[11:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_out     <= 12'h000;
            hsync_out   <= SYNC_IDLE;
            vsync_out   <= SYNC_IDLE;
            frame_start <= 1'b0;
        end else begin
            rgb_out     <= px;
            hsync_out   <= dl_hs[DL-1];
            vsync_out   <= dl_vs[DL-1];
            frame_start <= dl_org[DL-1];
        end
    end
endmodule

// File: tb/tb_layer_read_compositor.sv
// Bench for layer_read_compositor: MEM_LAT=1 and MEM_LAT=3 instances share stimulus, each fed by
// a behavioural framebuffer, with expected pixels queued at issue and popped by monitors.
module tb_layer_read_compositor;
    localparam int          H_RES = 640;
    localparam int          V_RES = 480;
    localparam logic [11:0] BG    = 12'h000;
    localparam logic [11:0] CUR   = 12'hFFF;
    localparam logic [14:0] IDLE  = {1'b0, 1'b1, 1'b1, 12'h000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, video_on, hsync_in, vsync_in;
    logic [9:0] x, y, cursor_x, cursor_y;
    logic [1:0] cursor_size;
    logic [2:0] show_layer;
    logic [11:0] rgb1, rgb3;
    logic        hs1, vs1, fs1, hs3, vs3, fs3;

    layer_read_compositor_if #(.ADDR_W(19)) m1 ();
    layer_read_compositor_if #(.ADDR_W(19)) m3 ();

    layer_read_compositor #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .x(x), .y(y), .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_size(cursor_size),
        .show_layer(show_layer), .mem(m1), .rgb_out(rgb1), .hsync_out(hs1), .vsync_out(vs1),
        .frame_start(fs1));

    layer_read_compositor #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .x(x), .y(y), .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_size(cursor_size),
        .show_layer(show_layer), .mem(m3), .rgb_out(rgb3), .hsync_out(hs3), .vsync_out(vs3),
        .frame_start(fs3));

    // Framebuffer contents: row 10 and row 11 are fixed patterns, the rest is hashed.
    function automatic logic [12:0] mem_word(int layer, int addr);
        logic [31:0] h;
        if (addr / H_RES == 10) begin
            case (layer)
                1:       return {1'b1, 12'h00F};
                2:       return {1'b1, 12'h0F0};
                default: return {1'b0, 12'hABC};
            endcase
        end
        if (addr / H_RES == 11) return {1'b0, 12'(addr * 7 + layer)};
        h = 32'(addr) * 32'h9E3779B1 ^ (32'(layer) << 20);
        return h[28:16];
    endfunction

    function automatic logic [38:0] rd_words(logic [18:0] a);
        return {mem_word(3, int'(a)), mem_word(2, int'(a)), mem_word(1, int'(a))};
    endfunction

    logic [38:0] p1;
    logic [38:0] p3 [3];
    always @(posedge clk) begin
        p1    <= rd_words(m1.rd_addr);
        p3[0] <= rd_words(m3.rd_addr);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign m1.l1_data = p1[12:0];
    assign m1.l2_data = p1[25:13];
    assign m1.l3_data = p1[38:26];
    assign m3.l1_data = p3[2][12:0];
    assign m3.l2_data = p3[2][25:13];
    assign m3.l3_data = p3[2][38:26];

    // Reference: {frame_start, hsync, vsync, rgb} for the pixel currently presented.
    function automatic logic [14:0] model_px();
        int xi, yi, cx, cy, s;
        logic in_range, hit;
        logic [11:0] rgb;
        logic [12:0] w;
        xi = int'(x); yi = int'(y); cx = int'(cursor_x); cy = int'(cursor_y);
        case (cursor_size)
            2'd0:    s = 4;
            2'd1:    s = 8;
            2'd2:    s = 20;
            default: s = 0;
        endcase
        in_range = video_on && xi < H_RES && yi < V_RES;
        hit = s > 0 && xi >= cx && xi < cx + s && yi >= cy && yi < cy + s
              && (xi == cx || xi == cx + s - 1 || yi == cy || yi == cy + s - 1);
        rgb = BG;
        for (int l = 1; l <= 3; l++) begin
            w = mem_word(l, yi * H_RES + xi);
            if (show_layer[l-1] && w[12]) rgb = w[11:0];
        end
        if (hit) rgb = CUR;
        if (!in_range) rgb = 12'h000;
        return {in_range && xi == 0 && yi == 0, hsync_in, vsync_in, rgb};
    endfunction

    function automatic logic [19:0] model_rd();
        int xi, yi;
        xi = int'(x); yi = int'(y);
        if (video_on && xi < H_RES && yi < V_RES) return {1'b1, 19'(yi * H_RES + xi)};
        return 20'd0;
    endfunction

    logic [14:0] exp1_q[$];
    logic [14:0] exp3_q[$];
    logic [19:0] rd_q[$];
    int n_chk = 0;
    int n_pass = 0;
    bit mon_on = 1'b0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic underflow(string name);
        n_chk++;
        $display("FAIL %s: output seen with empty expected queue (t=%0t)", name, $time);
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_on) begin
            if (exp1_q.size() == 0) underflow("lat1_pixel");
            else check("lat1_pixel", {17'd0, fs1, hs1, vs1, rgb1}, {17'd0, exp1_q.pop_front()});
            if (exp3_q.size() == 0) underflow("lat3_pixel");
            else check("lat3_pixel", {17'd0, fs3, hs3, vs3, rgb3}, {17'd0, exp3_q.pop_front()});
        end
    end

    always @(posedge clk) begin
        #1;
        if (mon_on) begin
            if (rd_q.size() == 0) underflow("rd_port");
            else begin
                logic [19:0] e;
                e = rd_q.pop_front();
                check("rd_lat1", {12'd0, m1.rd_en, m1.rd_addr}, {12'd0, e});
                check("rd_lat3", {12'd0, m3.rd_en, m3.rd_addr}, {12'd0, e});
            end
        end
    end

    task automatic drive_px(int xi, int yi, bit von, bit hs, bit vs);
        x = 10'(xi);
        y = 10'(yi);
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
        exp1_q.push_back(model_px());
        exp3_q.push_back(model_px());
        rd_q.push_back(model_rd());
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_rgb1"}, 32'(rgb1), 32'h0);
        check({tag, "_rgb3"}, 32'(rgb3), 32'h0);
        check({tag, "_hs1"}, 32'(hs1), 32'h1);
        check({tag, "_vs3"}, 32'(vs3), 32'h1);
        check({tag, "_fs1"}, 32'(fs1), 32'h0);
        check({tag, "_rden1"}, 32'(m1.rd_en), 32'h0);
        check({tag, "_rden3"}, 32'(m3.rd_en), 32'h0);
        check({tag, "_rdaddr1"}, 32'(m1.rd_addr), 32'h0);
    endtask

    task automatic release_reset();
        reset_n = 1'b1;
        mon_on = 1'b1;
        repeat (2) exp1_q.push_back(IDLE);
        repeat (4) exp3_q.push_back(IDLE);
    endtask

    task automatic rand_run(int n);
        int xi, yi;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                cursor_x = 10'($urandom_range(0, 639));
                cursor_y = 10'($urandom_range(0, 479));
                cursor_size = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 5) == 0) show_layer = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) begin
                xi = int'($urandom_range(0, 1023));
                yi = int'($urandom_range(0, 1023));
            end else begin
                xi = int'(cursor_x) + int'($urandom_range(0, 24)) - 2;
                yi = int'(cursor_y) + int'($urandom_range(0, 24)) - 2;
                if (xi < 0) xi = 0;
                if (yi < 0) yi = 0;
            end
            drive_px(xi, yi, $urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0,
                     $urandom_range(0, 15) != 0);
        end
    endtask

    initial begin
        reset_n = 1'b0; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        x = '0; y = '0; cursor_x = '0; cursor_y = '0; cursor_size = 2'b11; show_layer = 3'b111;

        // Reset held with random inputs: outputs must stay at reset values.
        repeat (5) begin
            @(negedge clk);
            video_on = 1'b1;
            x = 10'($urandom_range(0, 639));
            y = 10'($urandom_range(0, 479));
            hsync_in = 1'($urandom_range(0, 1));
            vsync_in = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check_reset_outputs("reset_held");
        release_reset();

        // Address generation and out-of-range pixels.
        drive_px(5, 2, 1, 1, 1);
        drive_px(639, 479, 1, 1, 1);
        drive_px(640, 3, 1, 1, 1);
        drive_px(10, 500, 1, 1, 1);
        drive_px(20, 20, 0, 1, 1);
        drive_px(1023, 1023, 1, 1, 1);

        // Layer priority on the fixed rows.
        foreach (show_layer[i]) begin end
        for (int s = 0; s < 4; s++) begin
            case (s)
                0: show_layer = 3'b111;
                1: show_layer = 3'b101;
                2: show_layer = 3'b001;
                default: show_layer = 3'b000;
            endcase
            for (int xi = 0; xi < 6; xi++) drive_px(xi, 10, 1, 1, 1);
        end
        show_layer = 3'b111;
        for (int xi = 0; xi < 6; xi++) drive_px(xi, 11, 1, 1, 1);

        // Cursor outline at (100,100), size 8, then hidden.
        cursor_x = 10'd100; cursor_y = 10'd100; cursor_size = 2'b01;
        drive_px(100, 103, 1, 1, 1);
        drive_px(107, 107, 1, 1, 1);
        drive_px(101, 101, 1, 1, 1);
        for (int yi = 98; yi < 110; yi++)
            for (int xi = 98; xi < 110; xi++) drive_px(xi, yi, 1, 1, 1);
        cursor_size = 2'b00;
        for (int yi = 99; yi < 105; yi++)
            for (int xi = 99; xi < 105; xi++) drive_px(xi, yi, 1, 1, 1);
        cursor_size = 2'b11;
        for (int yi = 99; yi < 109; yi++)
            for (int xi = 99; xi < 109; xi++) drive_px(xi, yi, 1, 1, 1);

        // Cursor clipped at the bottom-right corner.
        cursor_x = 10'd630; cursor_y = 10'd475; cursor_size = 2'b10;
        drive_px(639, 475, 1, 1, 1);
        drive_px(0, 475, 1, 1, 1);
        for (int yi = 473; yi < 482; yi++)
            for (int xi = 620; xi < 646; xi++) drive_px(xi, yi, 1, 1, 1);

        // Sync pulses and frame origin markers.
        for (int i = 0; i < 24; i++) drive_px(i, 5, 1, i != 7 && i != 8, i != 15);
        drive_px(0, 0, 1, 1, 0);
        drive_px(1, 0, 1, 1, 1);
        drive_px(0, 0, 0, 1, 1);
        drive_px(0, 1, 1, 1, 1);
        drive_px(0, 0, 1, 0, 1);

        rand_run(1500);

        // Asynchronous reset mid-stream, then resume.
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        mon_on = 1'b0;
        exp1_q.delete();
        exp3_q.delete();
        rd_q.delete();
        @(negedge clk);
        repeat (3) @(negedge clk);
        release_reset();
        drive_px(0, 0, 1, 1, 1);
        rand_run(800);

        repeat (8) drive_px(0, 0, 0, 1, 1);
        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
